// File: rtl/rand_pulse_sched.sv
// rtl/rand_pulse_sched.sv - random-gap pulse train scheduler driven by an upstream LFSR word
module rand_pulse_sched #(
  parameter int P_WIDTH_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [31:0]             lfsr,
  input  logic [31:0]             mask,
  input  logic [31:0]             min_gap,
  input  logic [P_WIDTH_BITS-1:0] width,
  input  logic [31:0]             n_pulses,
  output logic                    pulse,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             pulse_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, PULSE} state_t;

  state_t                  state, state_nx;
  logic [31:0]             mask_l, min_gap_l, n_pulses_l;
  logic [P_WIDTH_BITS-1:0] width_l, wid_cnt, wid_load;
  logic [31:0]             gap_cnt, gap_load, cnt_inc;
  logic [32:0]             gap_sum;
  logic                    last_high, run_done;
  logic                    pulse_nx, busy_nx, done_nx;

  // Gap sum is formed one bit wider so an overflow saturates instead of wrapping short.
  assign gap_sum   = {1'b0, lfsr & mask_l} + {1'b0, min_gap_l};
  assign gap_load  = gap_sum[32] ? 32'hFFFF_FFFF : gap_sum[31:0];
  assign wid_load  = (width_l == '0) ? '0 : width_l - P_WIDTH_BITS'(1);
  assign cnt_inc   = pulse_cnt + 32'd1;
  assign last_high = (wid_cnt == '0);
  assign run_done  = (n_pulses_l != 32'd0) && (cnt_inc == n_pulses_l);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pulse      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pulse_cnt  <= '0;
      gap_cnt    <= '0;
      wid_cnt    <= '0;
      mask_l     <= '0;
      min_gap_l  <= '0;
      width_l    <= '0;
      n_pulses_l <= '0;
    end else begin
      state <= state_nx;
      pulse <= pulse_nx;
      busy  <= busy_nx;
      done  <= done_nx;
      case (state)
        IDLE: begin
          if (en) begin
            mask_l     <= mask;
            min_gap_l  <= min_gap;
            width_l    <= width;
            n_pulses_l <= n_pulses;
            pulse_cnt  <= '0;
          end
        end
        LOAD: gap_cnt <= gap_load;
        WAIT: begin
          if (en) begin
            if (gap_cnt == '0) wid_cnt <= wid_load;
            else               gap_cnt <= gap_cnt - 32'd1;
          end
        end
        PULSE: begin
          if (!last_high) wid_cnt   <= wid_cnt - P_WIDTH_BITS'(1);
          else            pulse_cnt <= cnt_inc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (en) state_nx = LOAD;
      LOAD:  state_nx = en ? WAIT : IDLE;
      WAIT: begin
        if (!en)                state_nx = IDLE;
        else if (gap_cnt == '0) state_nx = PULSE;
      end
      PULSE: begin
        // An en drop never cuts a pulse short; it only takes effect on the last high cycle.
        if (last_high) begin
          if (run_done || !en) state_nx = IDLE;
          else                 state_nx = LOAD;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pulse_nx = (state_nx == PULSE);
    busy_nx  = (state_nx != IDLE);
    done_nx  = (state == PULSE) && last_high && run_done;
  end

endmodule
